// File: rtl/sync_decode.sv
// Video sync decoder: locks onto frame sync, counts columns and lines, and
// emits accepted pixels with their coordinates one cycle after they arrive.
// Length, frame-count and sync-overlap errors are reported as single-cycle pulses.
module sync_decode #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_sync,
  input  logic        i_line_sync,
  input  logic        i_de,
  input  logic [7:0]  i_r,
  input  logic [7:0]  i_g,
  input  logic [7:0]  i_b,
  output logic        o_pix_vld,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_eof,
  output logic        o_locked,
  output logic        o_len_err,
  output logic        o_cnt_err,
  output logic        o_sync_err
);

  // state | meaning
  // SEEK  | waiting for a frame sync rising edge; all input ignored
  // LOCK  | tracking column/line counts within a frame
  typedef enum logic {SEEK, LOCK} state_t;

  localparam logic [10:0] H_MAX = 11'(H_ACTIVE);
  localparam logic [10:0] V_MAX = 11'(V_ACTIVE);

  state_t      state_q, state_d;
  logic        fs_q, de_q;
  logic [10:0] col_q, col_d, line_q, line_d;
  // Set when DE continues past H_ACTIVE; the saturated column alone cannot
  // tell a full line from an over-long one.
  logic        ovf_q, ovf_d;

  logic        pix_vld_d, sof_d, eol_d, eof_d;
  logic [7:0]  r_d, g_d, b_d;
  logic [10:0] x_d, y_d;
  logic        len_err_d, cnt_err_d, sync_err_d;

  logic        fs_rise, de_fall;
  logic [10:0] col_eff, line_eff;
  logic        ovf_eff;

  assign fs_rise  = i_frame_sync & ~fs_q;
  assign de_fall  = de_q & ~i_de;
  assign o_locked = (state_q == LOCK);

  // State, counters, edge detectors and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= SEEK;
      fs_q       <= 1'b0;
      de_q       <= 1'b0;
      col_q      <= '0;
      line_q     <= '0;
      ovf_q      <= 1'b0;
      o_pix_vld  <= 1'b0;
      o_r        <= '0;
      o_g        <= '0;
      o_b        <= '0;
      o_x        <= '0;
      o_y        <= '0;
      o_sof      <= 1'b0;
      o_eol      <= 1'b0;
      o_eof      <= 1'b0;
      o_len_err  <= 1'b0;
      o_cnt_err  <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      fs_q       <= i_frame_sync;
      de_q       <= i_de;
      col_q      <= col_d;
      line_q     <= line_d;
      ovf_q      <= ovf_d;
      o_pix_vld  <= pix_vld_d;
      o_r        <= r_d;
      o_g        <= g_d;
      o_b        <= b_d;
      o_x        <= x_d;
      o_y        <= y_d;
      o_sof      <= sof_d;
      o_eol      <= eol_d;
      o_eof      <= eof_d;
      o_len_err  <= len_err_d;
      o_cnt_err  <= cnt_err_d;
      o_sync_err <= sync_err_d;
    end
  end

  // Next state: frame restart takes priority over end-of-line, and the
  // restarted counters are the ones used for a pixel arriving in that cycle.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_d     = line_q;
    ovf_d      = ovf_q;
    col_eff    = col_q;
    line_eff   = line_q;
    ovf_eff    = ovf_q;
    pix_vld_d  = 1'b0;
    r_d        = o_r;
    g_d        = o_g;
    b_d        = o_b;
    x_d        = o_x;
    y_d        = o_y;
    sof_d      = 1'b0;
    eol_d      = 1'b0;
    eof_d      = 1'b0;
    len_err_d  = 1'b0;
    cnt_err_d  = 1'b0;
    sync_err_d = 1'b0;

    case (state_q)
      SEEK: begin
        if (fs_rise) begin
          state_d = LOCK;
          col_d   = '0;
          line_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      LOCK: begin
        if (fs_rise) begin
          cnt_err_d = (line_q != V_MAX) || (col_q != 11'd0);
          col_eff   = '0;
          line_eff  = '0;
          ovf_eff   = 1'b0;
        end else if (de_fall) begin
          len_err_d = (col_q != H_MAX) || ovf_q;
          col_eff   = '0;
          ovf_eff   = 1'b0;
          if (line_q < V_MAX) line_eff = line_q + 11'd1;
        end
        col_d  = col_eff;
        line_d = line_eff;
        ovf_d  = ovf_eff;

        if (i_de && i_line_sync) begin
          sync_err_d = 1'b1;
        end else if (i_de) begin
          if (col_eff < H_MAX) begin
            col_d = col_eff + 11'd1;
            if (line_eff < V_MAX) begin
              pix_vld_d = 1'b1;
              r_d       = i_r;
              g_d       = i_g;
              b_d       = i_b;
              x_d       = col_eff;
              y_d       = line_eff;
              sof_d     = (col_eff == 11'd0) && (line_eff == 11'd0);
              eol_d     = (col_eff == H_MAX - 11'd1);
              eof_d     = (col_eff == H_MAX - 11'd1) && (line_eff == V_MAX - 11'd1);
            end
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      default: state_d = SEEK;
    endcase
  end

endmodule
